// File: rtl/mmio_uart_ctrl_pkg.sv
// Shared MMIO definitions for the UART/counter responder: register addresses,
// status bit positions and the address-to-register decode used by the top level.
package mmio_uart_ctrl_pkg;

    localparam logic [31:0] MMIO_STATUS_ADDR    = 32'h8000_0000;
    localparam logic [31:0] MMIO_RX_DATA_ADDR   = 32'h8000_0004;
    localparam logic [31:0] MMIO_TX_DATA_ADDR   = 32'h8000_0008;
    localparam logic [31:0] MMIO_CYCLE_ADDR     = 32'h8000_0010;
    localparam logic [31:0] MMIO_INSTRET_ADDR   = 32'h8000_0014;
    localparam logic [31:0] MMIO_CNT_CLEAR_ADDR = 32'h8000_0018;

    localparam int STATUS_TX_NOT_FULL_BIT  = 0;
    localparam int STATUS_RX_NOT_EMPTY_BIT = 1;
    localparam int STATUS_TX_OVERFLOW_BIT  = 2;

    // One entry per mapped register; anything outside the map is REG_NONE.
    typedef enum logic [2:0] {
        REG_NONE,
        REG_STATUS,
        REG_RX_DATA,
        REG_TX_DATA,
        REG_CYCLE,
        REG_INSTRET,
        REG_CNT_CLEAR
    } mmio_reg_e;

    // Full 32-bit compare so aliases of the window never hit a register.
    function automatic mmio_reg_e decode_reg(input logic [31:0] addr);
        mmio_reg_e sel;
        case (addr)
            MMIO_STATUS_ADDR:    sel = REG_STATUS;
            MMIO_RX_DATA_ADDR:   sel = REG_RX_DATA;
            MMIO_TX_DATA_ADDR:   sel = REG_TX_DATA;
            MMIO_CYCLE_ADDR:     sel = REG_CYCLE;
            MMIO_INSTRET_ADDR:   sel = REG_INSTRET;
            MMIO_CNT_CLEAR_ADDR: sel = REG_CNT_CLEAR;
            default:             sel = REG_NONE;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with an asynchronous head read. Occupancy is tracked by an
// explicit counter one bit wider than the pointers, so full and empty are never
// ambiguous. DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo
    import mmio_uart_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic             do_push;
    logic             do_pop;

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);

    // A pop on an empty FIFO is ignored; a push into a full FIFO only goes
    // through when the same cycle frees a slot with a pop.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    assign dout = mem[rd_ptr];

    // Storage array is not reset; only the pointers define what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy bookkeeping; reset flushes the FIFO.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mmio_uart_ctrl.sv
// MMIO responder for the CPU load/store port: decodes the 0x8000_00xx window,
// buffers UART RX/TX bytes in two FIFOs, and keeps the cycle and retired
// instruction counters. Loads return data one cycle after the strobe.
module mmio_uart_ctrl
    import mmio_uart_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic        re,
    input  logic        inst_retired,
    output logic [31:0] rdata,
    input  logic [7:0]  uart_rx_data_out,
    input  logic        uart_rx_data_out_valid,
    output logic        uart_rx_data_out_ready,
    output logic [7:0]  uart_tx_data_in,
    output logic        uart_tx_data_in_valid,
    input  logic        uart_tx_data_in_ready
);

    mmio_reg_e   rd_sel;
    mmio_reg_e   wr_sel;

    logic        rx_full;
    logic        rx_empty;
    logic [7:0]  rx_head;
    logic        rx_push;
    logic        rx_pop;

    logic        tx_full;
    logic        tx_empty;
    logic        tx_store;
    logic        tx_push;
    logic        tx_pop;
    logic        tx_drop;

    logic        tx_overflow;
    logic [31:0] cycle_count;
    logic [31:0] instret_count;
    logic        cnt_clear;

    logic [31:0] status_word;
    logic [31:0] read_value;

    logic        unused_wdata_bits;

    // Only the low byte of a store is meaningful; fold the rest away.
    assign unused_wdata_bits = ^wdata[31:8];

    // Decode loads and stores independently; an idle strobe selects nothing.
    always_comb begin
        rd_sel = REG_NONE;
        wr_sel = REG_NONE;
        if (re) begin
            rd_sel = decode_reg(addr);
        end
        if (we) begin
            wr_sel = decode_reg(addr);
        end
    end

    assign uart_rx_data_out_ready = !rst && !rx_full;
    assign rx_push = uart_rx_data_out_valid && uart_rx_data_out_ready;
    assign rx_pop  = (rd_sel == REG_RX_DATA) && !rx_empty;

    assign uart_tx_data_in_valid = !tx_empty;
    assign tx_pop   = uart_tx_data_in_valid && uart_tx_data_in_ready;
    assign tx_store = (wr_sel == REG_TX_DATA);
    assign tx_push  = tx_store && (!tx_full || tx_pop);
    assign tx_drop  = tx_store && tx_full && !tx_pop;

    assign cnt_clear = (wr_sel == REG_CNT_CLEAR);

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_rx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (rx_push),
        .din   (uart_rx_data_out),
        .pop   (rx_pop),
        .dout  (rx_head),
        .full  (rx_full),
        .empty (rx_empty)
    );

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tx_push),
        .din   (wdata[7:0]),
        .pop   (tx_pop),
        .dout  (uart_tx_data_in),
        .full  (tx_full),
        .empty (tx_empty)
    );

    // Sticky overflow: set by a dropped TX byte, cleared by any status store.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_overflow <= 1'b0;
        end else if (wr_sel == REG_STATUS) begin
            tx_overflow <= 1'b0;
        end else if (tx_drop) begin
            tx_overflow <= 1'b1;
        end
    end

    // Free-running counters; a clear store beats the same cycle's increment.
    always_ff @(posedge clk) begin
        if (rst || cnt_clear) begin
            cycle_count   <= '0;
            instret_count <= '0;
        end else begin
            cycle_count <= cycle_count + 32'd1;
            if (inst_retired) begin
                instret_count <= instret_count + 32'd1;
            end
        end
    end

    // Status word assembled from the current FIFO flags and overflow bit.
    always_comb begin
        status_word = '0;
        status_word[STATUS_TX_NOT_FULL_BIT]  = !tx_full;
        status_word[STATUS_RX_NOT_EMPTY_BIT] = !rx_empty;
        status_word[STATUS_TX_OVERFLOW_BIT]  = tx_overflow;
    end

    // Load mux sees pre-edge values, so reads never include this cycle's update.
    always_comb begin
        read_value = '0;
        case (rd_sel)
            REG_STATUS:  read_value = status_word;
            REG_RX_DATA: read_value = rx_empty ? 32'd0 : {24'd0, rx_head};
            REG_CYCLE:   read_value = cycle_count;
            REG_INSTRET: read_value = instret_count;
            default:     read_value = '0;
        endcase
    end

    // Registered load data, held until the next load strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= read_value;
        end
    end

endmodule

// File: tb/tb_mmio_uart_ctrl.sv
// Directed bench for mmio_uart_ctrl: drives CPU loads/stores and the UART
// handshakes on the falling edge and checks hand-computed values.
module tb_mmio_uart_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        we;
    logic        re;
    logic        inst_retired;
    logic [31:0] rdata;
    logic [7:0]  uart_rx_data_out;
    logic        uart_rx_data_out_valid;
    logic        uart_rx_data_out_ready;
    logic [7:0]  uart_tx_data_in;
    logic        uart_tx_data_in_valid;
    logic        uart_tx_data_in_ready;

    int vectors     = 0;
    int miscompares = 0;

    logic [31:0] rd_val;

    always #5 clk = ~clk;

    mmio_uart_ctrl #(
        .FIFO_DEPTH (8)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .addr                   (addr),
        .wdata                  (wdata),
        .we                     (we),
        .re                     (re),
        .inst_retired           (inst_retired),
        .rdata                  (rdata),
        .uart_rx_data_out       (uart_rx_data_out),
        .uart_rx_data_out_valid (uart_rx_data_out_valid),
        .uart_rx_data_out_ready (uart_rx_data_out_ready),
        .uart_tx_data_in        (uart_tx_data_in),
        .uart_tx_data_in_valid  (uart_tx_data_in_valid),
        .uart_tx_data_in_ready  (uart_tx_data_in_ready)
    );

    // Drive one CPU bus cycle starting at a falling edge, then idle the bus.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input logic w, input logic r);
        addr  = a;
        wdata = d;
        we    = w;
        re    = r;
        @(negedge clk);
        addr  = '0;
        wdata = '0;
        we    = 1'b0;
        re    = 1'b0;
    endtask

    // Load returns the value registered on the edge after the strobe.
    task automatic cpuLoad(input logic [31:0] a, output logic [31:0] data);
        applyStimulus(a, 32'd0, 1'b0, 1'b1);
        data = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        assert (observed === expected) else begin
            miscompares++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Watchdog so the run always ends even if the sequence stalls.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst                    = 1'b1;
        addr                   = '0;
        wdata                  = '0;
        we                     = 1'b0;
        re                     = 1'b0;
        inst_retired           = 1'b0;
        uart_rx_data_out       = '0;
        uart_rx_data_out_valid = 1'b0;
        uart_tx_data_in_ready  = 1'b0;

        repeat (2) @(negedge clk);
        checkOutput("reset_rx_ready", {31'd0, uart_rx_data_out_ready}, 32'd0);
        checkOutput("reset_tx_valid", {31'd0, uart_tx_data_in_valid}, 32'd0);
        checkOutput("reset_rdata", rdata, 32'd0);
        rst = 1'b0;

        $display("[TB] status after reset");
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_after_reset", rd_val, 32'h1);
        checkOutput("tx_valid_idle", {31'd0, uart_tx_data_in_valid}, 32'd0);
        checkOutput("rx_ready_idle", {31'd0, uart_rx_data_out_ready}, 32'd1);
        cpuLoad(32'h8000_000C, rd_val);
        checkOutput("unmapped_read", rd_val, 32'h0);

        $display("[TB] RX path");
        uart_rx_data_out_valid = 1'b1;
        uart_rx_data_out       = 8'h41;
        @(negedge clk);
        uart_rx_data_out       = 8'h42;
        @(negedge clk);
        uart_rx_data_out_valid = 1'b0;
        uart_rx_data_out       = 8'h00;
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_rx_pending", rd_val, 32'h3);
        cpuLoad(32'h8000_0004, rd_val);
        checkOutput("rx_byte0", rd_val, 32'h41);
        cpuLoad(32'h8000_0004, rd_val);
        checkOutput("rx_byte1", rd_val, 32'h42);
        cpuLoad(32'h8000_0004, rd_val);
        checkOutput("rx_empty_read", rd_val, 32'h0);
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_rx_drained", rd_val, 32'h1);

        $display("[TB] TX overflow");
        uart_tx_data_in_ready = 1'b0;
        for (int i = 0; i < 9; i++) begin
            applyStimulus(32'h8000_0008, 32'hABCD_0010 + 32'(i), 1'b1, 1'b0);
        end
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_tx_overflow", rd_val, 32'h4);
        uart_tx_data_in_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("tx_drain_valid", {31'd0, uart_tx_data_in_valid}, 32'd1);
            checkOutput("tx_drain_byte", {24'd0, uart_tx_data_in}, 32'h10 + 32'(i));
            @(negedge clk);
        end
        checkOutput("tx_drained_valid", {31'd0, uart_tx_data_in_valid}, 32'd0);
        uart_tx_data_in_ready = 1'b0;
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_overflow_sticky", rd_val, 32'h5);
        applyStimulus(32'h8000_0000, 32'h1234_5678, 1'b1, 1'b0);
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_overflow_cleared", rd_val, 32'h1);

        $display("[TB] TX full with simultaneous push and pop");
        for (int i = 0; i < 8; i++) begin
            applyStimulus(32'h8000_0008, 32'h20 + 32'(i), 1'b1, 1'b0);
        end
        uart_tx_data_in_ready = 1'b1;
        applyStimulus(32'h8000_0008, 32'h28, 1'b1, 1'b0);
        uart_tx_data_in_ready = 1'b0;
        checkOutput("tx_full_head", {24'd0, uart_tx_data_in}, 32'h21);
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_full_no_overflow", rd_val, 32'h0);
        uart_tx_data_in_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checkOutput("tx_full_drain_byte", {24'd0, uart_tx_data_in}, 32'h21 + 32'(i));
            @(negedge clk);
        end
        checkOutput("tx_full_drained", {31'd0, uart_tx_data_in_valid}, 32'd0);
        uart_tx_data_in_ready = 1'b0;

        $display("[TB] counters");
        applyStimulus(32'h8000_0018, 32'd0, 1'b1, 1'b0);
        for (int i = 0; i < 100; i++) begin
            inst_retired = (i % 2 == 0);
            @(negedge clk);
        end
        inst_retired = 1'b0;
        cpuLoad(32'h8000_0010, rd_val);
        checkOutput("cycle_count_100", rd_val, 32'd100);
        cpuLoad(32'h8000_0014, rd_val);
        checkOutput("instret_count_50", rd_val, 32'd50);
        inst_retired = 1'b1;
        applyStimulus(32'h8000_0018, 32'hFFFF_FFFF, 1'b1, 1'b0);
        inst_retired = 1'b0;
        cpuLoad(32'h8000_0010, rd_val);
        checkOutput("cycle_after_clear", rd_val, 32'd0);
        cpuLoad(32'h8000_0014, rd_val);
        checkOutput("instret_after_clear", rd_val, 32'd0);

        $display("[TB] cycle counter wrap");
        force dut.cycle_count = 32'hFFFF_FFFF;
        #1;
        release dut.cycle_count;
        cpuLoad(32'h8000_0010, rd_val);
        checkOutput("cycle_preset", rd_val, 32'hFFFF_FFFF);
        cpuLoad(32'h8000_0010, rd_val);
        checkOutput("cycle_wrap", rd_val, 32'd0);

        $display("[TB] reset mid-operation");
        uart_rx_data_out_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            uart_rx_data_out = 8'h51 + 8'(i);
            @(negedge clk);
        end
        uart_rx_data_out_valid = 1'b0;
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_rx_queued", rd_val, 32'h3);
        rst = 1'b1;
        #1;
        checkOutput("rx_ready_in_reset", {31'd0, uart_rx_data_out_ready}, 32'd0);
        @(negedge clk);
        checkOutput("rdata_lost_on_reset", rdata, 32'd0);
        rst = 1'b0;
        cpuLoad(32'h8000_0000, rd_val);
        checkOutput("status_after_flush", rd_val, 32'h1);
        cpuLoad(32'h8000_0004, rd_val);
        checkOutput("rx_after_flush", rd_val, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/mmio_uart_ctrl.md
# mmio_uart_ctrl

Memory-mapped I/O responder between the CPU's execute-stage load/store port and the on-chip `uart`. It decodes CPU accesses in the 0x8000_00xx window. It buffers UART traffic in RX and TX FIFOs so the core never stalls on serial timing. It also owns the cycle and retired-instruction counters that software reads.

## Interface
Parameters:
- `FIFO_DEPTH`, default 8: entries per FIFO; power of two, ≥ 2.

Ports:
- `clk`  in  1  core clock
- `rst`  in  1  reset; one clock, synchronous, active-high
- `addr`  in  32  CPU byte address of the current access
- `wdata`  in  32  CPU store data; only [7:0] used for TX
- `we`  in  1  CPU store strobe
- `re`  in  1  CPU load strobe
- `inst_retired`  in  1  one-cycle pulse per retired instruction
- `rdata`  out  32  load data, registered
- `uart_rx_data_out`  in  8  byte from the UART receiver
- `uart_rx_data_out_valid`  in  1  receiver byte valid
- `uart_rx_data_out_ready`  out  1  accept the receiver byte
- `uart_tx_data_in`  out  8  byte to the UART transmitter
- `uart_tx_data_in_valid`  out  1  transmit byte valid
- `uart_tx_data_in_ready`  in  1  transmitter can accept a byte

## Operation
Address map. All other addresses read 0; stores to them are ignored.
- 0x8000_0000 status (R):
  - bit0 = TX FIFO not full
  - bit1 = RX FIFO not empty
  - bit2 = sticky TX overflow
  - other bits 0
- 0x8000_0000 (W): a store of any value clears the overflow bit.
- 0x8000_0004 RX data (R):
  - returns {24'b0, head byte} and pops the RX FIFO.
  - If the RX FIFO is empty, returns 0 and does not pop.
- 0x8000_0008 TX data (W):
  - pushes wdata[7:0] into the TX FIFO.
  - If the TX FIFO is full, the byte is dropped and overflow is set.
- 0x8000_0010 cycle counter (R).
- 0x8000_0014 instruction counter (R).
- 0x8000_0018 (W): a store of any value zeroes both counters.

RX path:
- `uart_rx_data_out_ready` = !rst && RX FIFO not full.
- A byte is pushed on valid && ready.

TX path:
- `uart_tx_data_in_valid` = TX FIFO not empty.
- `uart_tx_data_in` = TX FIFO head, driven combinationally from FIFO storage.
- The FIFO pops on valid && ready.

Counters:
- 32-bit; wrap 0xFFFF_FFFF → 0.
- The cycle counter increments every non-reset cycle.
- The instruction counter increments when `inst_retired` is high.
- A clear store wins over that cycle's increment: both counters read 0 on the next cycle.

`re` and `we` in the same cycle are decoded independently; the CPU does not issue both.

## Timing
Reset values:
- `rdata` = 0
- both FIFOs empty
- overflow = 0
- counters = 0
- `uart_tx_data_in_valid` = 0
- `uart_rx_data_out_ready` = 0 while `rst` is high, 1 from the first cycle after.

Loads:
- `rdata` is valid exactly one cycle after `re`, matching dmem/BIOS latency.
- `rdata` holds until the next `re`.
- Counter and status reads return the values present at the edge where `re` is sampled, i.e. before that cycle's increment or push.

FIFO behaviour:
- A push is visible to status and to the opposite side one cycle after the push edge; there is no fall-through.
- A push and pop in the same cycle on a full FIFO are both performed; the count is unchanged and nothing is dropped.
- A pop on an empty FIFO is never performed; an empty FIFO cannot be popped in the same cycle it receives its first push.
- Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally. Full/empty come from an explicit count of log2(FIFO_DEPTH)+1 bits.

Reset mid-operation:
- `rst` in any cycle flushes both FIFOs and clears everything else on that edge.
- A pending `rdata` is lost: it reads 0 the cycle after `rst`.

## Structure
- Address constants (0x8000_0000/04/08/10/14/18) and status bit indices go in a shared `mmio_defs.vh` include. cpu.v uses the same include for its `uart_*` decode.
- One sub-module, `sync_fifo` (parameters WIDTH, DEPTH), instantiated twice with WIDTH = 8.
- The sub-module has push/pop/full/empty/dout ports and an asynchronous head read.
- Decode, counters and the `rdata` register live in the top level.

## Test plan
- Reset, then load 0x8000_0000 → `rdata` = 0x1 next cycle; `uart_tx_data_in_valid` = 0; `uart_rx_data_out_ready` = 1.
- UART delivers 0x41, then 0x42:
  - status reads 0x3;
  - two loads of 0x8000_0004 return 0x41, then 0x42;
  - a third load returns 0 with no pop, and status reads 0x1.
- Hold `uart_tx_data_in_ready` = 0 and store 9 bytes (0x10..0x18) with FIFO_DEPTH = 8:
  - status bit0 = 0 and bit2 = 1;
  - release ready → exactly 0x10..0x17 emerge in order;
  - a store to 0x8000_0000 clears bit2.
- Full TX FIFO with ready = 1 and a store in the same cycle → that store is accepted, the count is unchanged, and overflow stays 0.
- Run 100 cycles with `inst_retired` high every other cycle:
  - 0x8000_0010 reads 100 and 0x8000_0014 reads 50, relative to the post-reset origin;
  - a store to 0x8000_0018, then a load → both read 0 on the cycle after the clear.
- Preset the cycle counter to 0xFFFF_FFFF through a force → the next read is 0. Asserting `rst` with 3 RX bytes queued → status reads 0x1 afterwards.
